// File: rtl/lcd_readback_checker.sv
// Purpose: reads back a rectangle from the lcd driver and compares every pixel against the expected grid pattern.
// Latency: start to command needs only lcd ready; done pulses one cycle after the final accepted beat, or after a bad-rect/timeout exit.
// Backpressure: accepts one beat per cycle in STREAM only; waits on lcd ready before issuing the read; optional CRC via `LCD_READBACK_CRC_EN.
module lcd_readback_checker #(
  parameter int CoordinateWidth = 9,
  parameter int CommandWidth    = 3,
  parameter int PixelWidth      = 16,
  parameter int CountWidth      = 20,
  parameter int GridShift       = 4,
  parameter logic [PixelWidth-1:0]   GridPixel       = 16'hFFFF,
  parameter int TimeoutCount    = 65535,
  parameter logic [CommandWidth-1:0] CommandNone     = '0,
  parameter logic [CommandWidth-1:0] CommandReadRect = CommandWidth'(2)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic [CoordinateWidth-1:0] x0,
  input  logic [CoordinateWidth-1:0] x1,
  input  logic [CoordinateWidth-1:0] y0,
  input  logic [CoordinateWidth-1:0] y1,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic                       timeout,
  output logic                       bad_rect,
  output logic [CountWidth-1:0]      mismatch_count,
  output logic [CountWidth-1:0]      pixel_count,
  output logic [CoordinateWidth-1:0] first_err_x,
  output logic [CoordinateWidth-1:0] first_err_y,
  output logic [PixelWidth-1:0]      first_err_pixel,
  output logic [15:0]                crc,
  output logic [CommandWidth-1:0]    command,
  input  logic                       ready,
  output logic [CoordinateWidth-1:0] rect_x0,
  output logic [CoordinateWidth-1:0] rect_x1,
  output logic [CoordinateWidth-1:0] rect_y0,
  output logic [CoordinateWidth-1:0] rect_y1,
  input  logic [PixelWidth-1:0]      rect_pixel_read,
  input  logic                       rect_pixel_read_valid,
  output logic                       rect_pixel_read_ready
);

  localparam int TimerWidth = $clog2(TimeoutCount + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_STREAM,
    S_DONE
  } state_t;

  state_t                     state_q, state_d;
  logic [CoordinateWidth-1:0] rect_x0_q, rect_x0_d, rect_x1_q, rect_x1_d;
  logic [CoordinateWidth-1:0] rect_y0_q, rect_y0_d, rect_y1_q, rect_y1_d;
  logic [CoordinateWidth-1:0] cx_q, cx_d, cy_q, cy_d;
  logic [TimerWidth-1:0]      timer_q, timer_d;
  logic [CountWidth-1:0]      pixel_count_q, pixel_count_d;
  logic [CountWidth-1:0]      mismatch_count_q, mismatch_count_d;
  logic [CoordinateWidth-1:0] first_err_x_q, first_err_x_d, first_err_y_q, first_err_y_d;
  logic [PixelWidth-1:0]      first_err_pixel_q, first_err_pixel_d;
  logic                       timeout_q, timeout_d;
  logic                       bad_rect_q, bad_rect_d;
  logic                       pass_q, pass_d;

  logic                       beat;
  logic                       on_grid;
  logic                       pixel_bad;
  logic [GridShift-1:0]       rel_x_lo, rel_y_lo;
  logic [PixelWidth-1:0]      expected_pixel;

`ifdef LCD_READBACK_CRC_EN
  logic [15:0] crc_q, crc_d;

  // CRC-16-CCITT (poly 0x1021), one whole pixel folded in MSB first.
  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic [PixelWidth-1:0] d);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = PixelWidth - 1; i >= 0; i--) begin
      fb = r[15] ^ d[i];
      r  = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  assign crc = crc_q;
`else
  assign crc = '0;
`endif

  // Only the low GridShift bits of the relative position matter, and modulo
  // subtraction of the low bits equals the low bits of the full difference.
  assign rel_x_lo       = cx_q[GridShift-1:0] - rect_x0_q[GridShift-1:0];
  assign rel_y_lo       = cy_q[GridShift-1:0] - rect_y0_q[GridShift-1:0];
  assign on_grid        = (rel_x_lo == '0) || (rel_y_lo == '0);
  assign expected_pixel = on_grid ? GridPixel : '0;

  assign beat      = (state_q == S_STREAM) && rect_pixel_read_valid;
  assign pixel_bad = beat && (rect_pixel_read != expected_pixel);

  assign busy                  = (state_q == S_ISSUE) || (state_q == S_STREAM);
  assign done                  = (state_q == S_DONE);
  assign rect_pixel_read_ready = (state_q == S_STREAM);
  assign command               = ((state_q == S_ISSUE) && ready) ? CommandReadRect : CommandNone;

  assign pass            = pass_q;
  assign timeout         = timeout_q;
  assign bad_rect        = bad_rect_q;
  assign mismatch_count  = mismatch_count_q;
  assign pixel_count     = pixel_count_q;
  assign first_err_x     = first_err_x_q;
  assign first_err_y     = first_err_y_q;
  assign first_err_pixel = first_err_pixel_q;
  assign rect_x0         = rect_x0_q;
  assign rect_x1         = rect_x1_q;
  assign rect_y0         = rect_y0_q;
  assign rect_y1         = rect_y1_q;

  // Next-state: sequencing, raster walk, comparison and result capture.
  always_comb begin
    state_d           = state_q;
    rect_x0_d         = rect_x0_q;
    rect_x1_d         = rect_x1_q;
    rect_y0_d         = rect_y0_q;
    rect_y1_d         = rect_y1_q;
    cx_d              = cx_q;
    cy_d              = cy_q;
    timer_d           = timer_q;
    pixel_count_d     = pixel_count_q;
    mismatch_count_d  = mismatch_count_q;
    first_err_x_d     = first_err_x_q;
    first_err_y_d     = first_err_y_q;
    first_err_pixel_d = first_err_pixel_q;
    timeout_d         = timeout_q;
    bad_rect_d        = bad_rect_q;
    pass_d            = pass_q;
`ifdef LCD_READBACK_CRC_EN
    crc_d             = crc_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          rect_x0_d         = x0;
          rect_x1_d         = x1;
          rect_y0_d         = y0;
          rect_y1_d         = y1;
          cx_d              = x0;
          cy_d              = y0;
          timer_d           = '0;
          pixel_count_d     = '0;
          mismatch_count_d  = '0;
          first_err_x_d     = '0;
          first_err_y_d     = '0;
          first_err_pixel_d = '0;
          timeout_d         = 1'b0;
          bad_rect_d        = 1'b0;
          pass_d            = 1'b0;
`ifdef LCD_READBACK_CRC_EN
          // A fresh run starts from the CCITT seed, not from the reset value.
          crc_d             = 16'hFFFF;
`endif
          if ((x1 < x0) || (y1 < y0)) begin
            bad_rect_d = 1'b1;
            state_d    = S_DONE;
          end else begin
            state_d    = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        if (ready) state_d = S_STREAM;
      end

      S_STREAM: begin
        if (beat) begin
          timer_d       = '0;
          pixel_count_d = pixel_count_q + CountWidth'(1);
`ifdef LCD_READBACK_CRC_EN
          crc_d         = crc16_step(crc_q, rect_pixel_read);
`endif
          if (pixel_bad) begin
            if (mismatch_count_q != '1) mismatch_count_d = mismatch_count_q + CountWidth'(1);
            if (mismatch_count_q == '0) begin
              first_err_x_d     = cx_q;
              first_err_y_d     = cy_q;
              first_err_pixel_d = rect_pixel_read;
            end
          end
          if (cx_q == rect_x1_q) begin
            cx_d = rect_x0_q;
            cy_d = cy_q + CoordinateWidth'(1);
          end else begin
            cx_d = cx_q + CoordinateWidth'(1);
          end
          if ((cx_q == rect_x1_q) && (cy_q == rect_y1_q)) begin
            state_d = S_DONE;
            pass_d  = (mismatch_count_d == '0) && !timeout_q && !bad_rect_q;
          end
        end else if (timer_q == TimerWidth'(TimeoutCount - 1)) begin
          timeout_d = 1'b1;
          pass_d    = 1'b0;
          state_d   = S_DONE;
        end else begin
          timer_d = timer_q + TimerWidth'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q           <= S_IDLE;
      rect_x0_q         <= '0;
      rect_x1_q         <= '0;
      rect_y0_q         <= '0;
      rect_y1_q         <= '0;
      cx_q              <= '0;
      cy_q              <= '0;
      timer_q           <= '0;
      pixel_count_q     <= '0;
      mismatch_count_q  <= '0;
      first_err_x_q     <= '0;
      first_err_y_q     <= '0;
      first_err_pixel_q <= '0;
      timeout_q         <= 1'b0;
      bad_rect_q        <= 1'b0;
      pass_q            <= 1'b0;
`ifdef LCD_READBACK_CRC_EN
      crc_q             <= '0;
`endif
    end else begin
      state_q           <= state_d;
      rect_x0_q         <= rect_x0_d;
      rect_x1_q         <= rect_x1_d;
      rect_y0_q         <= rect_y0_d;
      rect_y1_q         <= rect_y1_d;
      cx_q              <= cx_d;
      cy_q              <= cy_d;
      timer_q           <= timer_d;
      pixel_count_q     <= pixel_count_d;
      mismatch_count_q  <= mismatch_count_d;
      first_err_x_q     <= first_err_x_d;
      first_err_y_q     <= first_err_y_d;
      first_err_pixel_q <= first_err_pixel_d;
      timeout_q         <= timeout_d;
      bad_rect_q        <= bad_rect_d;
      pass_q            <= pass_d;
`ifdef LCD_READBACK_CRC_EN
      crc_q             <= crc_d;
`endif
    end
  end

endmodule

// File: tb/tb_lcd_readback_checker.sv
// Directed bench for lcd_readback_checker with a behavioural lcd read-side model.
// Rectangles are kept small and the idle timeout is shortened so the run stays short.
// Each comparison is an immediate assertion; the last line is the summary.
module tb_lcd_readback_checker;

  localparam int CW = 9;
  localparam int PW = 16;
  localparam int NW = 20;
  localparam int TO = 300;
  localparam logic [2:0] CMD_NONE = 3'd0;
  localparam logic [2:0] CMD_RD   = 3'd2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] x0 = '0, x1 = '0, y0 = '0, y1 = '0;
  logic          busy, done, pass, timeout, bad_rect;
  logic [NW-1:0] mismatch_count, pixel_count;
  logic [CW-1:0] first_err_x, first_err_y;
  logic [PW-1:0] first_err_pixel;
  logic [15:0]   crc;
  logic [2:0]    command;
  logic          lcd_ready = 1'b0;
  logic [CW-1:0] rect_x0, rect_x1, rect_y0, rect_y1;
  logic [PW-1:0] rect_pixel_read = '0;
  logic          rect_pixel_read_valid = 1'b0;
  logic          rect_pixel_read_ready;

  lcd_readback_checker #(.TimeoutCount(TO), .CommandNone(CMD_NONE), .CommandReadRect(CMD_RD)) dut (
    .clock(clock), .reset(reset), .start(start),
    .x0(x0), .x1(x1), .y0(y0), .y1(y1),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout), .bad_rect(bad_rect),
    .mismatch_count(mismatch_count), .pixel_count(pixel_count),
    .first_err_x(first_err_x), .first_err_y(first_err_y), .first_err_pixel(first_err_pixel),
    .crc(crc), .command(command), .ready(lcd_ready),
    .rect_x0(rect_x0), .rect_x1(rect_x1), .rect_y0(rect_y0), .rect_y1(rect_y1),
    .rect_pixel_read(rect_pixel_read), .rect_pixel_read_valid(rect_pixel_read_valid),
    .rect_pixel_read_ready(rect_pixel_read_ready)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // Results of the most recent run_check call.
  int          r_cmd, r_cmd_bad, r_beats, r_done_cyc, r_last_cyc;
  logic        r_done;
  logic [15:0] r_crc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d (0x%0h) expected=%0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [15:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 15; i >= 0; i--) begin
      if (r[15] ^ d[i]) r = (r << 1) ^ 16'h1021;
      else              r = r << 1;
    end
    return r;
  endfunction

  function automatic logic [15:0] grid_pix(input int mx, input int my, input int ox, input int oy);
    return (((mx - ox) % 16) == 0 || ((my - oy) % 16) == 0) ? 16'hFFFF : 16'h0000;
  endfunction

  // Starts a check and plays the lcd read side: ready held low for rdy_delay
  // cycles, valid randomly dropped gap_pct percent of the time, at most
  // stop_after beats, and pixel (bad_x,bad_y) replaced by bad_val.
  task automatic run_check(input int ax0, input int ax1, input int ay0, input int ay1,
                           input int rdy_delay, input int gap_pct, input int stop_after,
                           input int bad_x, input int bad_y, input logic [15:0] bad_val,
                           input int budget);
    int          mx, my, cyc, total;
    logic        v, rdy_s;
    logic [15:0] d;
    mx = ax0; my = ay0; cyc = 0;
    r_cmd = 0; r_cmd_bad = 0; r_beats = 0; r_done_cyc = -1; r_last_cyc = -1;
    r_done = 1'b0; r_crc = 16'hFFFF;
    total = (ax1 >= ax0 && ay1 >= ay0) ? (ax1 - ax0 + 1) * (ay1 - ay0 + 1) : 0;
    x0 = CW'(ax0); x1 = CW'(ax1); y0 = CW'(ay0); y1 = CW'(ay1);
    start = 1'b1;
    lcd_ready = (rdy_delay == 0);
    tick();
    start = 1'b0;
    while (!r_done && cyc < budget) begin
      lcd_ready = (cyc >= rdy_delay);
      v = (r_beats < total) && (r_beats < stop_after) && (int'($urandom_range(99)) >= gap_pct);
      d = (mx == bad_x && my == bad_y) ? bad_val : grid_pix(mx, my, ax0, ay0);
      rect_pixel_read_valid = v;
      rect_pixel_read = v ? d : 16'hDEAD;
      #1;
      if (command == CMD_RD) begin
        r_cmd++;
        if (!lcd_ready) r_cmd_bad++;
      end else if (command != CMD_NONE) begin
        r_cmd_bad++;
      end
      if (done) begin
        r_done = 1'b1;
        r_done_cyc = cyc;
      end
      rdy_s = rect_pixel_read_ready;
      @(posedge clock);
      #1;
      if (v && rdy_s) begin
        r_beats++;
        r_last_cyc = cyc;
        r_crc = crc_model(r_crc, d);
        if (mx == ax1) begin
          mx = ax0;
          my++;
        end else begin
          mx++;
        end
      end
      cyc++;
    end
    rect_pixel_read_valid = 1'b0;
    lcd_ready = 1'b1;
    chk("done_within_budget", 32'(r_done), 32'd1);
  endtask

  task automatic chk_crc(input string tag);
`ifdef LCD_READBACK_CRC_EN
    chk(tag, 32'(crc), 32'(r_crc));
`else
    chk(tag, 32'(crc), 32'd0);
`endif
  endtask

  initial begin
    // Reset values
    reset = 1'b1;
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_bad_rect", 32'(bad_rect), 0);
    chk("rst_pixel_count", 32'(pixel_count), 0);
    chk("rst_mismatch_count", 32'(mismatch_count), 0);
    chk("rst_command", 32'(command), 32'(CMD_NONE));
    chk("rst_read_ready", 32'(rect_pixel_read_ready), 0);
    chk("rst_crc", 32'(crc), 0);
    chk("rst_rect_x1", 32'(rect_x1), 0);
    reset = 1'b0;
    tick();

    // Correct grid, 32 x 24 = 768 pixels
    run_check(120, 151, 40, 63, 0, 0, 1 << 30, -1, -1, 16'h0, 2000);
    chk("grid_done_one_cycle", 32'(done), 0);
    chk("grid_cmd_count", 32'(r_cmd), 1);
    chk("grid_cmd_bad", 32'(r_cmd_bad), 0);
    chk("grid_pixel_count", 32'(pixel_count), 768);
    chk("grid_mismatch", 32'(mismatch_count), 0);
    chk("grid_pass", 32'(pass), 1);
    chk("grid_done_after_last", 32'(r_done_cyc - r_last_cyc), 1);
    chk("grid_busy_after", 32'(busy), 0);
    chk("grid_rect_x0", 32'(rect_x0), 120);
    chk("grid_rect_y1", 32'(rect_y1), 63);
    chk_crc("grid_crc");

    // One corrupted pixel at (130,50), off-grid so it expects 0
    run_check(120, 151, 40, 63, 0, 0, 1 << 30, 130, 50, 16'h1234, 2000);
    chk("bad_mismatch", 32'(mismatch_count), 1);
    chk("bad_first_x", 32'(first_err_x), 130);
    chk("bad_first_y", 32'(first_err_y), 50);
    chk("bad_first_pixel", 32'(first_err_pixel), 32'h1234);
    chk("bad_pass", 32'(pass), 0);
    chk("bad_pixel_count", 32'(pixel_count), 768);
    chk_crc("bad_crc");

    // Ready low for 100 cycles, then 30% valid gaps
    run_check(120, 151, 40, 63, 100, 30, 1 << 30, -1, -1, 16'h0, 4000);
    chk("gap_cmd_count", 32'(r_cmd), 1);
    chk("gap_cmd_bad", 32'(r_cmd_bad), 0);
    chk("gap_pixel_count", 32'(pixel_count), 768);
    chk("gap_mismatch", 32'(mismatch_count), 0);
    chk("gap_pass", 32'(pass), 1);
    chk("gap_done_after_last", 32'(r_done_cyc - r_last_cyc), 1);
    chk_crc("gap_crc");

    // Driver stalls after 10 beats
    run_check(120, 151, 40, 63, 0, 0, 10, -1, -1, 16'h0, 1000);
    chk("to_timeout", 32'(timeout), 1);
    chk("to_pass", 32'(pass), 0);
    chk("to_pixel_count", 32'(pixel_count), 10);
    chk("to_busy_after", 32'(busy), 0);

    // Inverted rectangle
    run_check(10, 5, 0, 0, 0, 0, 1 << 30, -1, -1, 16'h0, 10);
    chk("br_bad_rect", 32'(bad_rect), 1);
    chk("br_done_fast", 32'(r_done_cyc <= 1), 1);
    chk("br_no_command", 32'(r_cmd), 0);
    chk("br_pass", 32'(pass), 0);
    chk("br_timeout_cleared", 32'(timeout), 0);

    // Reset in the middle of a stream
    x0 = 9'd0; x1 = 9'd15; y0 = 9'd0; y1 = 9'd3;
    lcd_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    rect_pixel_read_valid = 1'b1;
    rect_pixel_read = 16'h0;
    repeat (20) tick();
    chk("mid_streaming", 32'(busy), 1);
    reset = 1'b1;
    rect_pixel_read_valid = 1'b0;
    tick();
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_pixel_count", 32'(pixel_count), 0);
    chk("mid_rst_mismatch", 32'(mismatch_count), 0);
    chk("mid_rst_read_ready", 32'(rect_pixel_read_ready), 0);
    chk("mid_rst_command", 32'(command), 32'(CMD_NONE));
    reset = 1'b0;
    tick();
    chk("mid_post_done", 32'(done), 0);

    // Restart on a single white row
    run_check(0, 15, 0, 0, 0, 0, 1 << 30, -1, -1, 16'h0, 200);
    chk("rs_pixel_count", 32'(pixel_count), 16);
    chk("rs_pass", 32'(pass), 1);
    chk("rs_mismatch", 32'(mismatch_count), 0);
    chk_crc("rs_crc");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
